// File: rtl/hex_frame_tx.sv
// rtl/hex_frame_tx.sv - snapshot of NUM_WORDS words sent as one uppercase-hex ASCII line over 8N1 UART
module hex_frame_tx #(
    parameter int          WORD_WIDTH = 32,
    parameter int          NUM_WORDS  = 4,
    parameter int          CLK_DIV    = 16,
    parameter logic [7:0]  SEP_CHAR   = 8'h20,
    parameter int          APPEND_LF  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            TX,
    output logic                            busy,
    output logic                            done
);

    localparam int NIBBLES = (WORD_WIDTH + 3) / 4;
    // digits, one separator or CR slot per word, optional LF
    localparam int CHARS   = NUM_WORDS * NIBBLES + NUM_WORDS + APPEND_LF;
    localparam int BAUD_W  = $clog2(CLK_DIV);
    localparam int CIDX_W  = $clog2(CHARS);
    localparam int NPOS_W  = $clog2(NIBBLES + 1);
    localparam int WIDX_W  = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                            state, state_n;
    logic [BAUD_W-1:0]                 baud, baud_n;
    logic [2:0]                        bit_idx, bit_idx_n;
    logic [CIDX_W-1:0]                 char_idx, char_idx_n;
    // nib_pos == NIBBLES is the separator/CR slot; word_idx == NUM_WORDS is the LF slot
    logic [NPOS_W-1:0]                 nib_pos, nib_pos_n;
    logic [WIDX_W-1:0]                 word_idx, word_idx_n;
    logic [NUM_WORDS*WORD_WIDTH-1:0]   snap, snap_n;
    logic                              tx_n, busy_n, done_n;

    logic [WORD_WIDTH-1:0]             word;
    logic [NIBBLES*4-1:0]              padded;
    logic [3:0]                        nib;
    logic [7:0]                        digit;
    logic [7:0]                        cur_char;
    logic                              baud_end;
    logic                              last_char;

    assign in_ready  = (state == IDLE) && !reset;
    assign baud_end  = (baud == BAUD_W'(CLK_DIV - 1));
    assign last_char = (char_idx == CIDX_W'(CHARS - 1));

    // Character select: pick the byte for the current (word, nibble) slot from the snapshot
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_idx == WIDX_W'(k)) begin
                word = snap[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
        padded = '0;
        padded[WORD_WIDTH-1:0] = word;
        nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (nib_pos == NPOS_W'(n)) begin
                nib = padded[4*(NIBBLES-1-n) +: 4];
            end
        end
        digit = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        if (word_idx == WIDX_W'(NUM_WORDS)) begin
            cur_char = 8'h0A;
        end else if (nib_pos == NPOS_W'(NIBBLES)) begin
            cur_char = (word_idx == WIDX_W'(NUM_WORDS - 1)) ? 8'h0D : SEP_CHAR;
        end else begin
            cur_char = digit;
        end
    end

    // Next-state and next registered outputs; the character load is folded into the transfer/stop edge
    always_comb begin
        state_n    = state;
        baud_n     = baud;
        bit_idx_n  = bit_idx;
        char_idx_n = char_idx;
        nib_pos_n  = nib_pos;
        word_idx_n = word_idx;
        snap_n     = snap;
        tx_n       = TX;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (in_valid) begin
                    state_n    = START;
                    snap_n     = in_data;
                    baud_n     = '0;
                    bit_idx_n  = '0;
                    char_idx_n = '0;
                    nib_pos_n  = '0;
                    word_idx_n = '0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                    tx_n      = cur_char[0];
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = cur_char[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (last_char) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        // back-to-back characters: next start bit with no idle gap
                        state_n    = START;
                        tx_n       = 1'b0;
                        char_idx_n = char_idx + CIDX_W'(1);
                        if (nib_pos == NPOS_W'(NIBBLES)) begin
                            nib_pos_n  = '0;
                            word_idx_n = word_idx + WIDX_W'(1);
                        end else begin
                            nib_pos_n = nib_pos + NPOS_W'(1);
                        end
                    end
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any line in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            nib_pos  <= '0;
            word_idx <= '0;
            snap     <= '0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            char_idx <= char_idx_n;
            nib_pos  <= nib_pos_n;
            word_idx <= word_idx_n;
            snap     <= snap_n;
            TX       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_hex_frame_tx.sv
// tb/tb_hex_frame_tx.sv - directed table-driven bench for hex_frame_tx across four configurations
module tb_hex_frame_tx;

    logic        clk;
    logic        reset;
    logic [95:0] din;
    logic [3:0]  vld;
    int          sel;
    int          checks;
    int          errors;

    logic tx_a, busy_a, done_a, rdy_a;
    logic tx_b, busy_b, done_b, rdy_b;
    logic tx_c, busy_c, done_c, rdy_c;
    logic tx_d, busy_d, done_d, rdy_d;
    logic tx_s, busy_s, done_s, rdy_s;

    // A: 2 x 8-bit words with LF
    hex_frame_tx #(.WORD_WIDTH(8), .NUM_WORDS(2), .CLK_DIV(4), .SEP_CHAR(8'h20), .APPEND_LF(1)) dut_a (
        .clk(clk), .reset(reset), .in_data(din[15:0]), .in_valid(vld[0]),
        .in_ready(rdy_a), .TX(tx_a), .busy(busy_a), .done(done_a));
    // B: 1 x 32-bit word with LF
    hex_frame_tx #(.WORD_WIDTH(32), .NUM_WORDS(1), .CLK_DIV(4), .SEP_CHAR(8'h20), .APPEND_LF(1)) dut_b (
        .clk(clk), .reset(reset), .in_data(din[31:0]), .in_valid(vld[1]),
        .in_ready(rdy_b), .TX(tx_b), .busy(busy_b), .done(done_b));
    // C: 1 x 10-bit word, CR only
    hex_frame_tx #(.WORD_WIDTH(10), .NUM_WORDS(1), .CLK_DIV(4), .SEP_CHAR(8'h20), .APPEND_LF(0)) dut_c (
        .clk(clk), .reset(reset), .in_data(din[9:0]), .in_valid(vld[2]),
        .in_ready(rdy_c), .TX(tx_c), .busy(busy_c), .done(done_c));
    // D: 3 x 32-bit words, CR only
    hex_frame_tx #(.WORD_WIDTH(32), .NUM_WORDS(3), .CLK_DIV(4), .SEP_CHAR(8'h20), .APPEND_LF(0)) dut_d (
        .clk(clk), .reset(reset), .in_data(din[95:0]), .in_valid(vld[3]),
        .in_ready(rdy_d), .TX(tx_d), .busy(busy_d), .done(done_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to the checker
    always_comb begin
        case (sel)
            0:       begin tx_s = tx_a; busy_s = busy_a; done_s = done_a; rdy_s = rdy_a; end
            1:       begin tx_s = tx_b; busy_s = busy_b; done_s = done_b; rdy_s = rdy_b; end
            2:       begin tx_s = tx_c; busy_s = busy_c; done_s = done_c; rdy_s = rdy_c; end
            default: begin tx_s = tx_d; busy_s = busy_d; done_s = done_d; rdy_s = rdy_d; end
        endcase
    end

    typedef struct {
        int           sel;
        logic [95:0]  data;
        int           nch;
        logic [255:0] exp;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Raise valid, pass the transfer edge, land on the first start-bit cycle
    task automatic handshake(input string name);
        vld[sel] = 1'b1;
        @(negedge clk);
        chk({name, "_start_bit"}, 64'(tx_s), 64'd0);
    endtask

    // Decode one line from the first start-bit cycle (t=0) to the done cycle (t=N)
    task automatic rx_line(input string name, input int n, input logic [255:0] exp,
                           input bit hold, input logic [95:0] new_din);
        int       nlen;
        int       bad_busy;
        int       bad_rdy;
        int       bad_done;
        logic [9:0] sh;
        nlen     = n * 40;
        bad_busy = 0;
        bad_rdy  = 0;
        bad_done = 0;
        sh       = '0;
        for (int t = 0; t < nlen; t++) begin
            if (t > 0) @(negedge clk);
            if (!hold && t == 0) vld = '0;
            if (hold && t == 100) din = new_din;
            if (busy_s !== 1'b1) bad_busy++;
            if (rdy_s !== 1'b0) bad_rdy++;
            if (done_s !== 1'b0) bad_done++;
            if (t % 4 == 2) begin
                sh[(t / 4) % 10] = tx_s;
                if ((t / 4) % 10 == 9) begin
                    chk($sformatf("%s_char%0d", name, t / 40), 64'(sh[8:1]),
                        64'(exp[(n - 1 - t / 40) * 8 +: 8]));
                    chk($sformatf("%s_frame%0d", name, t / 40), 64'({sh[9], sh[0]}), 64'd2);
                end
            end
        end
        @(negedge clk);
        chk({name, "_done_at_end"}, 64'(done_s), 64'd1);
        chk({name, "_busy_at_end"}, 64'(busy_s), 64'd0);
        chk({name, "_ready_at_end"}, 64'(rdy_s), 64'd1);
        chk({name, "_tx_idle_at_end"}, 64'(tx_s), 64'd1);
        chk({name, "_busy_gaps"}, 64'(bad_busy), 64'd0);
        chk({name, "_ready_during_line"}, 64'(bad_rdy), 64'd0);
        chk({name, "_early_done"}, 64'(bad_done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int bad;
        checks = 0;
        errors = 0;
        sel    = 0;
        vld    = '0;
        din    = '0;
        reset  = 1'b1;

        tv[0] = '{0, 96'hA53C, 7, 256'({8'h33, 8'h43, 8'h20, 8'h41, 8'h35, 8'h0D, 8'h0A})};
        tv[1] = '{1, 96'h09AF_F0A9, 10, 256'({8'h30, 8'h39, 8'h41, 8'h46, 8'h46, 8'h30,
                                              8'h41, 8'h39, 8'h0D, 8'h0A})};
        tv[2] = '{2, 96'h3FF, 4, 256'({8'h33, 8'h46, 8'h46, 8'h0D})};
        tv[3] = '{3, 96'h0, 27, 256'({"00000000 00000000 00000000", 8'h0D})};
        tv[4] = '{0, 96'h0F9E, 7, 256'({8'h39, 8'h45, 8'h20, 8'h30, 8'h46, 8'h0D, 8'h0A})};
        tv[5] = '{2, 96'h2A5, 4, 256'({8'h32, 8'h41, 8'h35, 8'h0D})};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset_tx%0d", s), 64'(tx_s), 64'd1);
            chk($sformatf("reset_busy%0d", s), 64'(busy_s), 64'd0);
            chk($sformatf("reset_done%0d", s), 64'(done_s), 64'd0);
            chk($sformatf("reset_ready%0d", s), 64'(rdy_s), 64'd1);
        end
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            sel = tv[i].sel;
            din = tv[i].data;
            handshake($sformatf("vec%0d", i));
            rx_line($sformatf("vec%0d", i), tv[i].nch, tv[i].exp, 1'b0, '0);
            repeat (3) @(negedge clk);
        end

        // Snapshot and backpressure: valid held, data changed mid-line, second line back-to-back
        sel = 0;
        din = 96'h1234;
        handshake("snap1");
        rx_line("snap1", 7, 256'({8'h33, 8'h34, 8'h20, 8'h31, 8'h32, 8'h0D, 8'h0A}), 1'b1, 96'hBEEF);
        @(negedge clk);
        chk("snap2_start_bit", 64'(tx_s), 64'd0);
        chk("snap2_busy", 64'(busy_s), 64'd1);
        rx_line("snap2", 7, 256'({8'h45, 8'h46, 8'h20, 8'h42, 8'h45, 8'h0D, 8'h0A}), 1'b0, '0);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of the second character
        din = 96'hA53C;
        handshake("rstmid");
        vld = '0;
        repeat (57) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_tx", 64'(tx_s), 64'd1);
        chk("rstmid_busy", 64'(busy_s), 64'd0);
        chk("rstmid_done", 64'(done_s), 64'd0);
        chk("rstmid_ready", 64'(rdy_s), 64'd1);
        bad = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done_s !== 1'b0 || tx_s !== 1'b1 || busy_s !== 1'b0) bad++;
        end
        chk("rstmid_quiet_after", 64'(bad), 64'd0);
        din = 96'h5A00;
        handshake("fresh");
        rx_line("fresh", 7, 256'({8'h30, 8'h30, 8'h20, 8'h35, 8'h41, 8'h0D, 8'h0A}), 1'b0, '0);
        repeat (3) @(negedge clk);

        // Reset wins over a simultaneous valid
        reset  = 1'b1;
        vld[0] = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        vld[0] = 1'b0;
        #1;
        chk("rstprio_busy", 64'(busy_s), 64'd0);
        chk("rstprio_tx", 64'(tx_s), 64'd1);
        chk("rstprio_ready", 64'(rdy_s), 64'd1);
        @(negedge clk);
        chk("rstprio_no_start", 64'(tx_s), 64'd1);
        chk("rstprio_no_busy", 64'(busy_s), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
